// File: rtl/axi3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi3_pkg
// Brief    : Shared AXI3 burst/response encodings and responder state type.
// Revision : 1.0
// ============================================================================
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_RESP = 2'd3
    } state_t;

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_t;

endpackage
`default_nettype wire

// File: rtl/axi3_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi3_burst_addr_gen
// Brief    : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi3_burst_addr_gen
    import axi3_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  logic [7:0]  i_len,
    input  logic [1:0]  i_burst,
    output logic [31:0] o_next_addr
);

    logic [1:0]  w_size_eff;
    logic [31:0] w_bytes;
    logic [31:0] w_incr;
    logic [31:0] w_wrap_mask;

    always_comb begin
        // The data bus is 32 bits wide, so wider beat sizes clamp to a word.
        w_size_eff  = (i_size > 3'd2) ? 2'd2 : i_size[1:0];
        w_bytes     = 32'd1 << w_size_eff;
        w_incr      = i_addr + w_bytes;
        w_wrap_mask = (({24'd0, i_len} + 32'd1) << w_size_eff) - 32'd1;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     o_next_addr = w_incr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi3_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi3_sram_slave
// Brief    : AXI3 responder over a word-addressed SRAM, one burst at a time.
// Revision : 1.0
// ============================================================================
module axi3_sram_slave
    import axi3_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h1c00_0000,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          ID_W        = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_axi3_ar_valid,
    output logic            io_axi3_ar_ready,
    input  logic [ID_W-1:0] io_axi3_ar_bits_id,
    input  logic [31:0]     io_axi3_ar_bits_addr,
    input  logic [7:0]      io_axi3_ar_bits_len,
    input  logic [2:0]      io_axi3_ar_bits_size,
    input  logic [1:0]      io_axi3_ar_bits_burst,
    output logic            io_axi3_r_valid,
    input  logic            io_axi3_r_ready,
    output logic [ID_W-1:0] io_axi3_r_bits_id,
    output logic [31:0]     io_axi3_r_bits_data,
    output logic [1:0]      io_axi3_r_bits_resp,
    output logic            io_axi3_r_bits_last,
    input  logic            io_axi3_aw_valid,
    output logic            io_axi3_aw_ready,
    input  logic [ID_W-1:0] io_axi3_aw_bits_id,
    input  logic [31:0]     io_axi3_aw_bits_addr,
    input  logic [7:0]      io_axi3_aw_bits_len,
    input  logic [2:0]      io_axi3_aw_bits_size,
    input  logic [1:0]      io_axi3_aw_bits_burst,
    input  logic            io_axi3_w_valid,
    output logic            io_axi3_w_ready,
    input  logic [ID_W-1:0] io_axi3_w_bits_id,
    input  logic [31:0]     io_axi3_w_bits_data,
    input  logic [3:0]      io_axi3_w_bits_strb,
    input  logic            io_axi3_w_bits_last,
    output logic            io_axi3_b_valid,
    input  logic            io_axi3_b_ready,
    output logic [ID_W-1:0] io_axi3_b_bits_id,
    output logic [1:0]      io_axi3_b_bits_resp
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN  = 32'(4 * DEPTH_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    prio_t             r_prio;
    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_dec;
    logic              r_slv;
    logic              r_rvalid;
    logic [ID_W-1:0]   r_rid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic              r_wready;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_ar_rdy;
    logic              w_aw_rdy;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_r_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_beat_last;
    logic              w_last_err;
    logic [31:0]       w_next_addr;
    logic [31:0]       w_look_addr;
    logic [31:0]       w_look_off;
    logic              w_look_in;
    logic [c_IDX_W-1:0] w_look_idx;
    logic [31:0]       w_look_data;
    logic              w_dec_fin;
    logic              w_slv_fin;
    logic              w_unused;

    axi3_burst_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    assign w_ar_hs     = io_axi3_ar_valid && w_ar_rdy;
    assign w_aw_hs     = io_axi3_aw_valid && w_aw_rdy;
    assign w_r_hs      = r_rvalid && io_axi3_r_ready;
    assign w_w_hs      = r_wready && io_axi3_w_valid;
    assign w_b_hs      = r_bvalid && io_axi3_b_ready;
    assign w_beat_last = (r_cnt == r_len);
    assign w_last_err  = (io_axi3_w_bits_last != w_beat_last);

    // One decoder serves the pending AR at grant, the upcoming read beat, or the current write beat.
    assign w_look_addr = (r_state == ST_IDLE) ? io_axi3_ar_bits_addr :
                         (r_state == ST_RD)   ? w_next_addr : r_addr;
    assign w_look_off  = w_look_addr - ADDR_BASE;
    assign w_look_in   = (w_look_addr >= ADDR_BASE) && (w_look_off < c_SPAN);
    assign w_look_idx  = w_look_off[c_IDX_W+1:2];
    assign w_look_data = r_mem[w_look_idx];
    assign w_dec_fin   = r_dec || !w_look_in;
    assign w_slv_fin   = r_slv || w_last_err;
    assign w_unused    = ^{io_axi3_w_bits_id, w_look_off[31:c_IDX_W+2], w_look_off[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ar_rdy    = 1'b0;
        w_aw_rdy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!reset) begin
                    w_ar_rdy = io_axi3_ar_valid && (!io_axi3_aw_valid || (r_prio == PRIO_READ));
                    w_aw_rdy = io_axi3_aw_valid && (!io_axi3_ar_valid || (r_prio == PRIO_WRITE));
                end
                if (w_ar_rdy) begin
                    w_state_nxt = ST_RD;
                end else if (w_aw_rdy) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD:      if (w_r_hs && w_beat_last) w_state_nxt = ST_IDLE;
            ST_WR:      if (w_w_hs && w_beat_last) w_state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio   <= PRIO_READ;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_dec    <= 1'b0;
            r_slv    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_id     <= io_axi3_ar_bits_id;
                r_addr   <= io_axi3_ar_bits_addr;
                r_len    <= io_axi3_ar_bits_len;
                r_size   <= io_axi3_ar_bits_size;
                r_burst  <= io_axi3_ar_bits_burst;
                r_cnt    <= '0;
                r_prio   <= PRIO_WRITE;
                r_rvalid <= 1'b1;
                r_rid    <= io_axi3_ar_bits_id;
                r_rdata  <= w_look_in ? w_look_data : 32'd0;
                r_rresp  <= w_look_in ? RESP_OKAY : RESP_DECERR;
                r_rlast  <= (io_axi3_ar_bits_len == 8'd0);
            end else if (w_aw_hs) begin
                r_id     <= io_axi3_aw_bits_id;
                r_addr   <= io_axi3_aw_bits_addr;
                r_len    <= io_axi3_aw_bits_len;
                r_size   <= io_axi3_aw_bits_size;
                r_burst  <= io_axi3_aw_bits_burst;
                r_cnt    <= '0;
                r_prio   <= PRIO_READ;
                r_wready <= 1'b1;
                r_dec    <= 1'b0;
                r_slv    <= 1'b0;
            end

            // Read beats are prefetched one ahead so the R fields stay registered during stalls.
            if (w_r_hs) begin
                if (w_beat_last) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 8'd1;
                    r_addr  <= w_next_addr;
                    r_rdata <= w_look_in ? w_look_data : 32'd0;
                    r_rresp <= w_look_in ? RESP_OKAY : RESP_DECERR;
                    r_rlast <= ((r_cnt + 8'd1) == r_len);
                end
            end

            if (w_w_hs) begin
                r_dec <= w_dec_fin;
                r_slv <= w_slv_fin;
                if (w_beat_last) begin
                    r_wready <= 1'b0;
                    r_bvalid <= 1'b1;
                    r_bid    <= r_id;
                    r_bresp  <= w_dec_fin ? RESP_DECERR :
                                w_slv_fin ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_addr <= w_next_addr;
                end
            end

            if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_w_hs && w_look_in) begin
            for (int i = 0; i < 4; i++) begin
                if (io_axi3_w_bits_strb[i]) begin
                    r_mem[w_look_idx][8*i +: 8] <= io_axi3_w_bits_data[8*i +: 8];
                end
            end
        end
    end

    assign io_axi3_ar_ready    = w_ar_rdy;
    assign io_axi3_aw_ready    = w_aw_rdy;
    assign io_axi3_r_valid     = r_rvalid;
    assign io_axi3_r_bits_id   = r_rid;
    assign io_axi3_r_bits_data = r_rdata;
    assign io_axi3_r_bits_resp = r_rresp;
    assign io_axi3_r_bits_last = r_rlast;
    assign io_axi3_w_ready     = r_wready;
    assign io_axi3_b_valid     = r_bvalid;
    assign io_axi3_b_bits_id   = r_bid;
    assign io_axi3_b_bits_resp = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi3_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi3_sram_slave
// Brief    : Directed scoreboard bench for axi3_sram_slave.
// Revision : 1.0
// ============================================================================
module tb_axi3_sram_slave;

    localparam int ID_W = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ar_valid, ar_ready;
    logic [ID_W-1:0] ar_id;
    logic [31:0]     ar_addr;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            r_valid, r_ready;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic            aw_valid, aw_ready;
    logic [ID_W-1:0] aw_id;
    logic [31:0]     aw_addr;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            w_valid, w_ready;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_data;
    logic [3:0]      w_strb;
    logic            w_last;
    logic            b_valid, b_ready;
    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;

    always #5 clock = ~clock;

    axi3_sram_slave #(.ADDR_BASE(32'h1c00_0000), .DEPTH_WORDS(16384), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .io_axi3_ar_valid(ar_valid), .io_axi3_ar_ready(ar_ready),
        .io_axi3_ar_bits_id(ar_id), .io_axi3_ar_bits_addr(ar_addr),
        .io_axi3_ar_bits_len(ar_len), .io_axi3_ar_bits_size(ar_size),
        .io_axi3_ar_bits_burst(ar_burst),
        .io_axi3_r_valid(r_valid), .io_axi3_r_ready(r_ready),
        .io_axi3_r_bits_id(r_id), .io_axi3_r_bits_data(r_data),
        .io_axi3_r_bits_resp(r_resp), .io_axi3_r_bits_last(r_last),
        .io_axi3_aw_valid(aw_valid), .io_axi3_aw_ready(aw_ready),
        .io_axi3_aw_bits_id(aw_id), .io_axi3_aw_bits_addr(aw_addr),
        .io_axi3_aw_bits_len(aw_len), .io_axi3_aw_bits_size(aw_size),
        .io_axi3_aw_bits_burst(aw_burst),
        .io_axi3_w_valid(w_valid), .io_axi3_w_ready(w_ready),
        .io_axi3_w_bits_id(w_id), .io_axi3_w_bits_data(w_data),
        .io_axi3_w_bits_strb(w_strb), .io_axi3_w_bits_last(w_last),
        .io_axi3_b_valid(b_valid), .io_axi3_b_ready(b_ready),
        .io_axi3_b_bits_id(b_id), .io_axi3_b_bits_resp(b_resp)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int    errors = 0;
    int    checks = 0;
    int    r_mode = 0;  // 0: r_ready high, 1: toggle, 2: low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    initial begin
        r_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (r_mode)
                0:       r_ready = 1'b1;
                1:       r_ready = ~r_ready;
                default: r_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each R/B handshake and checks R stability while stalled.
    logic  stall_prev = 1'b0;
    rexp_t held;
    initial begin
        rexp_t e;
        bexp_t be;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && r_valid)
                    chk("r_hold", {r_id, r_data, r_resp, r_last}, held);
                stall_prev = r_valid && !r_ready;
                held = {r_id, r_data, r_resp, r_last};
                if (r_valid && r_ready) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected: got %h expected none", {r_id, r_data, r_resp, r_last});
                    end else begin
                        e = rq.pop_front();
                        chk("r_beat", {r_id, r_data, r_resp, r_last}, e);
                    end
                end
                if (b_valid && b_ready) begin
                    if (bq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got %h expected none", {b_id, b_resp});
                    end else begin
                        be = bq.pop_front();
                        chk("b_resp", {b_id, b_resp}, be);
                    end
                end
            end
        end
    end

    // All drive tasks start and end at posedge+1.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit chk_lat);
        bit hs = 0;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd2; ar_burst = burst;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clock);
            if (ar_ready) hs = 1;
            @(posedge clock);
            #1;
        end
        ar_valid = 1'b0;
        if (!hs) begin
            timeout_fail("ar_handshake");
        end else if (chk_lat) begin
            @(negedge clock);
            chk("r_latency", {63'd0, r_valid}, 64'd1);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        bit hs = 0;
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd2; aw_burst = burst;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clock);
            if (aw_ready) hs = 1;
            @(posedge clock);
            #1;
        end
        aw_valid = 1'b0;
        if (!hs) timeout_fail("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit hs = 0;
        w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clock);
            if (w_ready) hs = 1;
            @(posedge clock);
            #1;
        end
        w_valid = 1'b0;
        if (!hs) timeout_fail("w_handshake");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && (rq.size() != 0 || bq.size() != 0); i++) @(posedge clock);
        @(posedge clock);
        #1;
        if (rq.size() != 0 || bq.size() != 0) timeout_fail("drain");
    endtask

    task automatic write1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
        bq.push_back('{id: id, resp: resp});
        send_aw(id, addr, 8'd0, 2'b01);
        send_w(data, strb, 1'b1);
        wait_drain();
    endtask

    task automatic read1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp);
        rq.push_back('{id: id, data: data, resp: resp, last: 1'b1});
        send_ar(id, addr, 8'd0, 2'b01, 1'b0);
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_id = 0; w_data = 0; w_strb = 0; w_last = 0;
        b_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outs", {25'd0, ar_ready, aw_ready, w_ready, r_valid, b_valid, r_data, r_resp, b_resp},
            64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single write then read with latency check.
        write1(4'd1, 32'h1c00_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
        rq.push_back('{id: 4'd2, data: 32'hDEAD_BEEF, resp: 2'b00, last: 1'b1});
        send_ar(4'd2, 32'h1c00_0010, 8'd0, 2'b01, 1'b1);
        wait_drain();

        // Preload words 0..3 with an INCR burst.
        bq.push_back('{id: 4'd3, resp: 2'b00});
        send_aw(4'd3, 32'h1c00_0000, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'(i), 4'hF, (i == 3));
        wait_drain();

        // INCR read with r_ready toggling.
        r_mode = 1;
        for (int i = 0; i < 4; i++)
            rq.push_back('{id: 4'd4, data: 32'(i), resp: 2'b00, last: (i == 3)});
        send_ar(4'd4, 32'h1c00_0000, 8'd3, 2'b01, 1'b1);
        wait_drain();
        r_mode = 0;

        // WRAP read starting mid-window: 0x08, 0x0C, 0x00, 0x04.
        rq.push_back('{id: 4'd5, data: 32'd2, resp: 2'b00, last: 1'b0});
        rq.push_back('{id: 4'd5, data: 32'd3, resp: 2'b00, last: 1'b0});
        rq.push_back('{id: 4'd5, data: 32'd0, resp: 2'b00, last: 1'b0});
        rq.push_back('{id: 4'd5, data: 32'd1, resp: 2'b00, last: 1'b1});
        send_ar(4'd5, 32'h1c00_0008, 8'd3, 2'b10, 1'b0);
        wait_drain();

        // Decode boundaries.
        read1(4'd6, 32'h0000_0000, 32'd0, 2'b11);
        read1(4'd6, 32'h1c01_0000, 32'd0, 2'b11);
        write1(4'd7, 32'h1c00_fffc, 32'h5A5A_1234, 4'hF, 2'b00);
        read1(4'd7, 32'h1c00_fffc, 32'h5A5A_1234, 2'b00);
        write1(4'd7, 32'h0000_0000, 32'h1234_5678, 4'hF, 2'b11);

        // Early w_last: the counted second beat is still accepted, response SLVERR.
        bq.push_back('{id: 4'd8, resp: 2'b10});
        send_aw(4'd8, 32'h1c00_0040, 8'd1, 2'b01);
        send_w(32'h0000_00A0, 4'hF, 1'b1);
        send_w(32'h0000_00A1, 4'hF, 1'b0);
        wait_drain();

        // Strobe merge.
        write1(4'd9, 32'h1c00_0020, 32'hAABB_CCDD, 4'hF, 2'b00);
        write1(4'd9, 32'h1c00_0020, 32'h1122_3344, 4'b0101, 2'b00);
        read1(4'd9, 32'h1c00_0020, 32'hAA22_CC44, 2'b00);

        // FIXED write burst leaves the last beat in place.
        bq.push_back('{id: 4'd10, resp: 2'b00});
        send_aw(4'd10, 32'h1c00_0030, 8'd2, 2'b00);
        send_w(32'hAAAA_0001, 4'hF, 1'b0);
        send_w(32'hAAAA_0002, 4'hF, 1'b0);
        send_w(32'hAAAA_0003, 4'hF, 1'b1);
        wait_drain();
        read1(4'd10, 32'h1c00_0030, 32'hAAAA_0003, 2'b00);
        write1(4'd11, 32'h1c00_0050, 32'h0101_0101, 4'hF, 2'b00);

        // Reset in the middle of a stalled read burst.
        r_mode = 2;
        send_ar(4'd12, 32'h1c00_0000, 8'd3, 2'b01, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("reset_midburst", {57'd0, r_valid, b_valid, w_ready, ar_ready, aw_ready, r_last, r_resp == 2'b00},
            64'd1);
        chk("reset_rdata", {32'd0, r_data}, 64'd0);
        r_mode = 0;

        // Arbitration: both requests pending from reset to the same word.
        @(posedge clock);
        #1;
        ar_valid = 1'b1; ar_id = 4'd13; ar_addr = 32'h1c00_0050; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01;
        aw_valid = 1'b1; aw_id = 4'd14; aw_addr = 32'h1c00_0050; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01;
        rq.push_back('{id: 4'd13, data: 32'h0101_0101, resp: 2'b00, last: 1'b1});
        bq.push_back('{id: 4'd14, resp: 2'b00});
        rq.push_back('{id: 4'd13, data: 32'h0202_0202, resp: 2'b00, last: 1'b1});
        @(negedge clock);
        chk("ready_in_reset", {62'd0, ar_ready, aw_ready}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("arb_first", {62'd0, ar_ready, aw_ready}, 64'd2);
        begin
            bit hs = 0;
            for (int i = 0; i < 100 && !hs; i++) begin
                @(negedge clock);
                if (aw_ready) begin
                    hs = 1;
                    chk("arb_second", {62'd0, ar_ready, aw_ready}, 64'd1);
                end
            end
            @(posedge clock);
            #1;
            aw_valid = 1'b0;
            if (!hs) timeout_fail("arb_aw");
        end
        send_w(32'h0202_0202, 4'hF, 1'b1);
        begin
            bit hs = 0;
            for (int i = 0; i < 100 && !hs; i++) begin
                @(negedge clock);
                if (ar_ready) hs = 1;
                @(posedge clock);
                #1;
            end
            ar_valid = 1'b0;
            if (!hs) timeout_fail("arb_ar_again");
        end
        wait_drain();

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi3_sram_slave.md
Name: axi3_sram_slave

Overview:
- AXI3 responder backed by a word-addressed on-chip SRAM model.
- Serves as the memory end of the core's AXI3 master port, for simulation and FPGA bring-up without an external controller.
- Accepts single or burst reads and writes (FIXED/INCR/WRAP), one transaction in flight at a time.
- Fair read/write arbitration; address decode against a configurable base window.

Parameters:
- ADDR_BASE, 32'h1c00_0000, byte address of word 0.
- DEPTH_WORDS, 16384, number of 32-bit words; must be a power of two.
- ID_W, 4, AXI ID width.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: synchronous, active-high reset.
- io_axi3_ar_valid in 1 / io_axi3_ar_ready out 1: read-address handshake.
- io_axi3_ar_bits_id in ID_W; io_axi3_ar_bits_addr in 32; io_axi3_ar_bits_len in 8 (beats-1); io_axi3_ar_bits_size in 3; io_axi3_ar_bits_burst in 2: read request fields.
- io_axi3_r_valid out 1 / io_axi3_r_ready in 1: read-data handshake.
- io_axi3_r_bits_id out ID_W; io_axi3_r_bits_data out 32; io_axi3_r_bits_resp out 2; io_axi3_r_bits_last out 1: read beat.
- io_axi3_aw_valid in 1 / io_axi3_aw_ready out 1; io_axi3_aw_bits_id/addr/len/size/burst in ID_W/32/8/3/2: write request.
- io_axi3_w_valid in 1 / io_axi3_w_ready out 1; io_axi3_w_bits_id in ID_W; io_axi3_w_bits_data in 32; io_axi3_w_bits_strb in 4; io_axi3_w_bits_last in 1: write beat.
- io_axi3_b_valid out 1 / io_axi3_b_ready in 1; io_axi3_b_bits_id out ID_W; io_axi3_b_bits_resp out 2: write response.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous, active-high, sampled on the rising edge of clock.
  - Reset forces state IDLE, all valid/ready outputs 0, r/b data fields 0, and arbitration priority to read.
  - SRAM contents are not cleared.
  - Reset asserted mid-burst abandons the transaction: no further beats and no B response.
- States: IDLE, RD, WR, WR_RESP.
- IDLE arbitration:
  - ar_ready = ar_valid && (!aw_valid || prio==READ).
  - aw_ready = aw_valid && (!ar_valid || prio==WRITE).
  - ar_ready and aw_ready are never both 1.
  - Grant latches id, addr, len, size, burst and beat counter = 0.
  - prio flips to the opposite type after each grant.
- Decode:
  - in_range = ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS, evaluated per beat.
  - Word index = (addr - ADDR_BASE) >> 2.
- Address advance per beat, with bytes = 1<<size:
  - FIXED (00): unchanged.
  - INCR (01): addr + bytes.
  - WRAP (10): wraps within an aligned (len+1)*bytes window.
  - Burst 11 is treated as INCR.
  - size > 2 is treated as 2.
- RD:
  - r_valid rises the cycle after the AR handshake.
  - One beat per cycle while r_ready is held high.
  - r fields are held stable while r_valid && !r_ready.
  - Out-of-range beat: data 0, resp DECERR (11); otherwise resp OKAY (00).
  - r_last = (counter == len).
  - After the last handshake, go to IDLE. ar_ready/aw_ready may assert in that next cycle.
- WR:
  - w_ready = 1 from the cycle after the AW handshake.
  - Each W handshake writes the bytes selected by strb (bit i → data[8i+7:8i]).
  - Out-of-range beats are dropped and set a sticky DECERR.
  - Protocol error when w_last disagrees with (counter == len). This sets a sticky SLVERR.
  - The burst always terminates on the counted beat len; w_ready = 0 afterwards.
- WR_RESP:
  - b_valid rises the cycle after the final W beat.
  - b_resp = DECERR if set, else SLVERR if set, else OKAY; b_id = latched id.
  - Return to IDLE after the B handshake.
- Read-after-write: a read granted after a write's B handshake returns the written data.

Decomposition:
- Shared package axi3_pkg holds:
  - Burst constants BURST_FIXED/INCR/WRAP.
  - Response constants RESP_OKAY/SLVERR/DECERR.
  - The responder state enum.
- One natural sub-module: axi3_burst_addr_gen, a combinational next-address unit (addr, size, len, burst → next addr), shared by the RD and WR paths.

Test Plan:
- Single write then read: AW addr 0x1c00_0010, len 0, strb 4'hF, data 0xDEADBEEF → b_resp 00; AR same addr → r_data 0xDEADBEEF, r_last 1, resp 00, one cycle after AR handshake.
- INCR read, len 3, addr 0x1c00_0000, preloaded 0..3, r_ready toggling every other cycle → data 0,1,2,3 in order, held stable while stalled, last only on beat 3.
- WRAP read, len 3, size 2, addr 0x1c00_0008 → words read from 0x08, 0x0C, 0x00, 0x04.
- ar_valid and aw_valid asserted together from reset, both held pending → read granted first, write next, then read again (alternation).
- Out-of-range: AR addr 0x0000_0000 → data 0, resp 11. Write len 1 with w_last on beat 0 → beat 1 still accepted, b_resp 10.
- Strobe merge: write 0x11223344 with strb 4'b0101 over 0xAABBCCDD → readback 0xAA22CC44. Assert reset mid-burst → all valids 0 next cycle, state IDLE.
